// File: rtl/rr_psel_multi.sv
// rr_psel_multi: multi-grant request selector with rotating priority.
// Each cycle up to REQS requests are granted out of a WIDTH-bit request
// vector. The scan starts at the priority pointer in rotating mode, or at
// index 0 in fixed mode. After a grant in rotating mode, the pointer moves
// to one past the last granted slot.
// Optional build macro: PSEL_STATS_EN adds a saturating grant counter on
// the stat_grants port.
module rr_psel_multi #(
    parameter int WIDTH  = 16,
    parameter int REQS   = 2,
    parameter int PTR_W  = $clog2(WIDTH),
    parameter int CNT_W  = $clog2(REQS + 1),
    parameter int STAT_W = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    rr_mode,
    input  logic [WIDTH-1:0]        req,
    output logic [WIDTH*REQS-1:0]   gnt_bus,
    output logic [CNT_W-1:0]        gnt_cnt,
    output logic                    empty,
    output logic [PTR_W-1:0]        ptr
`ifdef PSEL_STATS_EN
    ,
    output logic [STAT_W-1:0]       stat_grants
`endif
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] REQS_C   = CNT_W'(REQS);

    logic [PTR_W-1:0]            ptr_q;
    logic [PTR_W-1:0]            ptr_d;
    logic [PTR_W-1:0]            start_s;
    logic [PTR_W-1:0]            idx_s;
    logic [PTR_W-1:0]            last_s;
    logic [CNT_W-1:0]            cnt_s;
    logic                        grant_ok_s;
    logic [REQS-1:0][WIDTH-1:0]  gnt_arr_s;

    // Scan requests from the start index with explicit wrap, handing out grants in order
    always_comb begin
        gnt_arr_s  = '0;
        cnt_s      = '0;
        last_s     = '0;
        grant_ok_s = en && !reset;
        if (rr_mode) begin
            start_s = ptr_q;
        end else begin
            start_s = '0;
        end
        idx_s = start_s;
        for (int k = 0; k < WIDTH; k++) begin
            if (grant_ok_s && req[idx_s] && (cnt_s < REQS_C)) begin
                for (int j = 0; j < REQS; j++) begin
                    if (cnt_s == CNT_W'(j)) begin
                        gnt_arr_s[j][idx_s] = 1'b1;
                    end else begin
                        gnt_arr_s[j][idx_s] = gnt_arr_s[j][idx_s];
                    end
                end
                last_s = idx_s;
                cnt_s  = cnt_s + CNT_W'(1);
            end else begin
                last_s = last_s;
            end
            // Wrap compare instead of truncation: WIDTH need not be a power of two
            if (idx_s == LAST_IDX) begin
                idx_s = '0;
            end else begin
                idx_s = idx_s + PTR_W'(1);
            end
        end
    end

    // Next pointer: one past the last granted index, only when rotating and something was granted
    always_comb begin
        if (grant_ok_s && rr_mode && (cnt_s != '0)) begin
            if (last_s == LAST_IDX) begin
                ptr_d = '0;
            end else begin
                ptr_d = last_s + PTR_W'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Priority pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt_bus = gnt_arr_s;
    assign gnt_cnt = cnt_s;
    assign empty   = ~|req;
    assign ptr     = ptr_q;

`ifdef PSEL_STATS_EN
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_d;
    logic [STAT_W:0]   stat_sum_s;

    // Saturating accumulation of grants issued this cycle
    always_comb begin
        stat_sum_s = {1'b0, stat_q} + (STAT_W + 1)'(cnt_s);
        if (stat_sum_s[STAT_W]) begin
            stat_d = '1;
        end else begin
            stat_d = stat_sum_s[STAT_W-1:0];
        end
    end

    // Statistics counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_rr_psel_multi.sv
// Testbench for rr_psel_multi: an 8-wide/2-grant instance driven through a
// scoreboard of expected grants and pointers, plus a 6-wide/3-grant
// instance exercising a non-power-of-two wrap.
module tb_rr_psel_multi;

    logic        clock;
    logic        reset;
    logic        en;
    logic        rr_mode;
    logic [7:0]  req;
    logic [15:0] gnt_bus;
    logic [1:0]  gnt_cnt;
    logic        empty;
    logic [2:0]  ptr;

    logic        en6;
    logic        rr6;
    logic [5:0]  req6;
    logic [17:0] gnt6;
    logic [1:0]  cnt6;
    logic        empty6;
    logic [2:0]  ptr6;

`ifdef PSEL_STATS_EN
    logic [3:0]  stat_grants;
    logic [3:0]  stat6;
`endif

    int checks = 0;
    int errors = 0;
    logic [2:0] m_ptr;

    typedef struct packed {
        logic [15:0] gnt;
        logic [1:0]  cnt;
        logic        emp;
        logic [2:0]  pb;
        logic [2:0]  pa;
    } exp_t;

    exp_t sb[$];

    rr_psel_multi #(.WIDTH(8), .REQS(2), .STAT_W(4)) dut (
        .clock(clock), .reset(reset), .en(en), .rr_mode(rr_mode), .req(req),
        .gnt_bus(gnt_bus), .gnt_cnt(gnt_cnt), .empty(empty), .ptr(ptr)
`ifdef PSEL_STATS_EN
        , .stat_grants(stat_grants)
`endif
    );

    rr_psel_multi #(.WIDTH(6), .REQS(3), .STAT_W(4)) dut6 (
        .clock(clock), .reset(reset), .en(en6), .rr_mode(rr6), .req(req6),
        .gnt_bus(gnt6), .gnt_cnt(cnt6), .empty(empty6), .ptr(ptr6)
`ifdef PSEL_STATS_EN
        , .stat_grants(stat6)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference: list the set bits in scan order, take the first two
    function automatic void model(input logic e, input logic r, input logic [7:0] q,
                                  input logic [2:0] p, output logic [15:0] g,
                                  output logic [1:0] c, output logic [2:0] np);
        int s;
        int n;
        int idx;
        int last;
        g = 16'h0000;
        n = 0;
        last = 0;
        s = r ? int'(p) : 0;
        if (e) begin
            for (int k = 0; k < 8; k++) begin
                idx = (s + k) % 8;
                if (q[idx] && n < 2) begin
                    g[n * 8 + idx] = 1'b1;
                    n++;
                    last = idx;
                end
            end
        end
        c = 2'(n);
        np = (e && r && n > 0) ? 3'((last + 1) % 8) : p;
    endfunction

    // Apply inputs just after a rising edge, check combinational outputs at the
    // falling edge, check the pointer just after the next rising edge
    task automatic drive(input logic e, input logic r, input logic [7:0] q,
                         input logic [15:0] eg, input logic [1:0] ec, input logic [2:0] pa);
        exp_t it;
        en = e;
        rr_mode = r;
        req = q;
        sb.push_back('{gnt: eg, cnt: ec, emp: (q == 8'h00), pb: m_ptr, pa: pa});
        m_ptr = pa;
        @(negedge clock);
        it = sb.pop_front();
        check_val("gnt_bus", 32'(gnt_bus), 32'(it.gnt));
        check_val("gnt_cnt", 32'(gnt_cnt), 32'(it.cnt));
        check_val("empty", 32'(empty), 32'(it.emp));
        check_val("ptr_before", 32'(ptr), 32'(it.pb));
        @(posedge clock);
        #1;
        check_val("ptr_after", 32'(ptr), 32'(it.pa));
    endtask

    task automatic drive_model(input logic e, input logic r, input logic [7:0] q);
        logic [15:0] g;
        logic [1:0]  c;
        logic [2:0]  np;
        model(e, r, q, m_ptr, g, c, np);
        drive(e, r, q, g, c, np);
    endtask

    initial begin
        reset = 1'b1;
        en = 1'b1;
        rr_mode = 1'b1;
        req = 8'hFF;
        en6 = 1'b0;
        rr6 = 1'b1;
        req6 = 6'h00;
        m_ptr = 3'd0;
        #2;
        check_val("rst_gnt", 32'(gnt_bus), 32'h0);
        check_val("rst_cnt", 32'(gnt_cnt), 32'h0);
        check_val("rst_empty0", 32'(empty), 32'h0);
        check_val("rst_ptr", 32'(ptr), 32'h0);
        req = 8'h00;
        #1;
        check_val("rst_empty1", 32'(empty), 32'h1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Rotation with wrap
        drive(1'b1, 1'b1, 8'b1011_0110, 16'h0402, 2'd2, 3'd3);
        drive(1'b1, 1'b1, 8'b1011_0110, 16'h2010, 2'd2, 3'd6);
        drive(1'b1, 1'b1, 8'b1011_0110, 16'h0280, 2'd2, 3'd2);
        // Move pointer to 5, then fixed mode holds it
        drive(1'b1, 1'b1, 8'b0001_0000, 16'h0010, 2'd1, 3'd5);
        drive(1'b1, 1'b0, 8'b1011_0110, 16'h0402, 2'd2, 3'd5);
        drive(1'b1, 1'b0, 8'b1011_0110, 16'h0402, 2'd2, 3'd5);
        // Rotating mode resumes from the held pointer
        drive(1'b1, 1'b1, 8'b1011_0110, 16'h8020, 2'd2, 3'd0);
        // Single request, then empty
        drive(1'b1, 1'b1, 8'b0100_0000, 16'h0040, 2'd1, 3'd7);
        drive(1'b1, 1'b1, 8'b0000_0000, 16'h0000, 2'd0, 3'd7);
        // Enable low
        drive(1'b0, 1'b1, 8'hFF, 16'h0000, 2'd0, 3'd7);

        // Random mix against the reference model
        for (int i = 0; i < 40; i++) begin
            drive_model(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                        ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom));
        end

        // Non-power-of-two width: set ptr6 to 4, then wrap across WIDTH-1
        en6 = 1'b1;
        rr6 = 1'b1;
        req6 = 6'b00_1000;
        @(negedge clock);
        check_val("w6_gnt_a", 32'(gnt6), 32'h00008);
        @(posedge clock);
        #1;
        check_val("w6_ptr_a", 32'(ptr6), 32'h4);
        req6 = 6'b11_0011;
        @(negedge clock);
        check_val("w6_gnt_b", 32'(gnt6), 32'h01810);
        check_val("w6_cnt_b", 32'(cnt6), 32'h3);
        @(posedge clock);
        #1;
        check_val("w6_ptr_b", 32'(ptr6), 32'h1);
        en6 = 1'b0;

        // Mid-cycle reset with enable high
        drive(1'b1, 1'b1, 8'b0100_0000, 16'h0040, 2'd1, 3'd7);
        en = 1'b1;
        rr_mode = 1'b1;
        req = 8'hFF;
        #2;
        reset = 1'b1;
        #1;
        check_val("mid_rst_ptr", 32'(ptr), 32'h0);
        check_val("mid_rst_gnt", 32'(gnt_bus), 32'h0);
        check_val("mid_rst_cnt", 32'(gnt_cnt), 32'h0);
        check_val("mid_rst_empty", 32'(empty), 32'h0);
        @(posedge clock);
        #1;
        check_val("rst_edge_ptr", 32'(ptr), 32'h0);
        reset = 1'b0;
        m_ptr = 3'd0;

`ifdef PSEL_STATS_EN
        // Two grants per cycle: 2, 4, ... 14, then saturate at 15
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            check_val("stat", 32'(stat_grants), (2 * k > 15) ? 32'd15 : 32'(2 * k));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
